// File: rtl/parity_frame_checker.sv
// Serial 7-bit frame receiver: start(0), nibble A..D MSB first, parity, stop(1).
// One line bit is sampled per clk edge. Results are published one edge after
// the stop bit is sampled, together with a one-cycle valid pulse. The FSM is
// back in IDLE at that point, so a start bit can be taken with no idle gap.
module parity_frame_checker #(
  parameter bit ODD_PAR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic       valid,
  output logic       par_err,
  output logic       frm_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t     state, state_nx;
  logic [1:0] idx;       // position of the next data bit in shreg
  logic [3:0] shreg;     // nibble being assembled
  logic       par_bit;   // captured parity bit
  logic       stop_bit;  // captured stop bit
  logic       done;      // stop bit sampled last edge; publish results now
  logic       frm_bad;
  logic       par_bad;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; no state aborts on line activity, every bit is taken.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!rx) state_nx = DATA;
      DATA:      if (idx == 2'd0) state_nx = PARITY;
      PARITY:    state_nx = STOP;
      STOP:      state_nx = rx ? IDLE : WAIT_IDLE;
      // Only a sampled 1 releases the line; that same cycle cannot be a start.
      WAIT_IDLE: if (rx) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Frame capture: data bits, parity and stop bit as they are sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= 2'd3;
      shreg    <= 4'd0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (!rx) idx <= 2'd3;
        DATA: begin
          shreg[idx] <= rx;
          idx        <= idx - 2'd1;
        end
        PARITY: par_bit <= rx;
        STOP: begin
          stop_bit <= rx;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign par_bad = ((^shreg) ^ par_bit) != ODD_PAR;
  assign frm_bad = ~stop_bit;

  // Result publication: outputs only move on the valid cycle, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      data_out <= 4'd0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      valid <= done;
      if (done) begin
        data_out <= shreg;
        par_err  <= par_bad;
        frm_err  <= frm_bad;
        // One count per bad frame regardless of how many errors it carries.
        if ((par_bad || frm_bad) && err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench: an even-parity and an odd-parity instance, each with its
// own line. Expected results are queued when a stop bit is driven and popped
// when valid is observed; between pulses the outputs must hold.
module tb_parity_frame_checker;

  typedef struct {
    logic [3:0] d;
    logic       pe;
    logic       fe;
    logic [7:0] ec;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_e = 1'b1, rx_o = 1'b1;
  logic [3:0] data_e, data_o;
  logic       valid_e, valid_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
  logic [7:0] ec_e, ec_o;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  exp_t q_e[$], q_o[$];
  exp_t last_e, last_o;
  logic [7:0] mcnt_e = 8'd0, mcnt_o = 8'd0;

  parity_frame_checker #(.ODD_PAR(1'b0)) u_even (
    .clk(clk), .rst(rst), .rx(rx_e), .data_out(data_e), .valid(valid_e),
    .par_err(pe_e), .frm_err(fe_e), .err_cnt(ec_e), .busy(busy_e));

  parity_frame_checker #(.ODD_PAR(1'b1)) u_odd (
    .clk(clk), .rst(rst), .rx(rx_o), .data_out(data_o), .valid(valid_o),
    .par_err(pe_o), .frm_err(fe_o), .err_cnt(ec_o), .busy(busy_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.d = 4'd0; e.pe = 1'b0; e.fe = 1'b0; e.ec = 8'd0; e.cyc = 0;
    return e;
  endfunction

  // Compare one instance's outputs against the scoreboard.
  task automatic mon(input bit sel, input logic v, input logic [3:0] d,
                     input logic pe, input logic fe, input logic [7:0] ec);
    exp_t e;
    if (v) begin
      if ((sel ? q_o.size() : q_e.size()) == 0) begin
        chk(sel ? "o_unexp_valid" : "e_unexp_valid", 1, 0);
      end else begin
        e = sel ? q_o.pop_front() : q_e.pop_front();
        chk(sel ? "o_vld_cyc" : "e_vld_cyc", cyc, e.cyc);
        chk(sel ? "o_data" : "e_data", d, e.d);
        chk(sel ? "o_par_err" : "e_par_err", pe, e.pe);
        chk(sel ? "o_frm_err" : "e_frm_err", fe, e.fe);
        chk(sel ? "o_err_cnt" : "e_err_cnt", ec, e.ec);
        if (sel) last_o = e; else last_e = e;
      end
    end else begin
      e = sel ? last_o : last_e;
      chk(sel ? "o_hold" : "e_hold", {d, pe, fe, ec}, {e.d, e.pe, e.fe, e.ec});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0, valid_e, data_e, pe_e, fe_e, ec_e);
      mon(1'b1, valid_o, data_o, pe_o, fe_o, ec_o);
    end
  end

  // Drive one full frame on the selected line; optionally release reset on
  // the same cycle the start bit is presented.
  task automatic send(input logic [3:0] d, input logic p, input logic s,
                      input bit sel, input bit rel_rst);
    logic [6:0] b;
    exp_t e;
    b = {1'b0, d, p, s};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0 && rel_rst) rst = 1'b0;
      if (sel) rx_o = b[6-i]; else rx_e = b[6-i];
      if (i == 6) begin
        e.d   = d;
        e.pe  = ((^d) ^ p) != sel;
        e.fe  = ~s;
        e.cyc = cyc + 2;
        if (sel) begin
          if ((e.pe || e.fe) && mcnt_o != 8'hFF) mcnt_o++;
          e.ec = mcnt_o; q_o.push_back(e);
        end else begin
          if ((e.pe || e.fe) && mcnt_e != 8'hFF) mcnt_e++;
          e.ec = mcnt_e; q_e.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_e = 1'b1; rx_o = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {data_e, valid_e, pe_e, fe_e, ec_e, busy_e}, 0);
    chk(tag, {data_o, valid_o, pe_o, fe_o, ec_o, busy_o}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] b;
    last_e = zero_exp();
    last_o = zero_exp();

    // Reset state, then a start bit on the very first edge after release.
    #3 chk_zero("rst_state");
    send(4'b1011, 1'b1, 1'b1, 1'b0, 1'b1);   // clean even frame
    idle(3);
    send(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);   // parity error
    idle(3);

    // Framing error: all zeros, line held low, then released.
    send(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_e = 1'b0;
      chk("wait_idle_busy", busy_e, 1);
    end
    @(negedge clk);
    rx_e = 1'b1;
    @(negedge clk);
    chk("wait_idle_exit", busy_e, 0);
    send(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Back-to-back frames, no idle gap.
    send(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
    send(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset while the D bit is on the line.
    b = {1'b0, 4'b1101, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_e = b[6-i];
    end
    chk("mid_frame_busy", busy_e, 1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    q_e.delete(); q_o.delete();
    mcnt_e = 8'd0; mcnt_o = 8'd0;
    last_e = zero_exp(); last_o = zero_exp();
    rx_e = 1'b1;
    @(posedge clk);
    #1 chk_zero("rst_held");
    repeat (8) @(posedge clk);
    #1 chk_zero("rst_no_valid");
    send(4'b1001, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Exhaustive correct-parity sweep on both parity senses.
    for (int n = 0; n < 16; n++) begin
      send(4'(n), ^(4'(n)), 1'b1, 1'b0, 1'b0);
      send(4'(n), ~(^(4'(n))), 1'b1, 1'b1, 1'b0);
    end
    idle(3);

    // Saturation: 260 parity-error frames back to back.
    for (int n = 0; n < 260; n++)
      send(4'(n), ~(^(4'(n))), 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("sat_final", ec_e, 8'hFF);
    chk("q_e_drained", q_e.size(), 0);
    chk("q_o_drained", q_o.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
